// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU function codes, writeback state enum and width defaults shared by the ALU and writeback.
package alu_pkg;

   localparam int DEFAULT_DATA_WIDTH        = 16;
   localparam int DEFAULT_ALU_CONTROL_WIDTH = 4;

   localparam logic [DEFAULT_ALU_CONTROL_WIDTH-1:0] ALU_NOP = 4'b0000;
   localparam logic [DEFAULT_ALU_CONTROL_WIDTH-1:0] ALU_MUL = 4'b0001;
   localparam logic [DEFAULT_ALU_CONTROL_WIDTH-1:0] ALU_DIV = 4'b0010;
   localparam logic [DEFAULT_ALU_CONTROL_WIDTH-1:0] ALU_SUB = 4'b0011;
   localparam logic [DEFAULT_ALU_CONTROL_WIDTH-1:0] ALU_AND = 4'b0100;
   localparam logic [DEFAULT_ALU_CONTROL_WIDTH-1:0] ALU_OR  = 4'b0101;
   localparam logic [DEFAULT_ALU_CONTROL_WIDTH-1:0] ALU_SLL = 4'b1000;
   localparam logic [DEFAULT_ALU_CONTROL_WIDTH-1:0] ALU_SLR = 4'b1001;
   localparam logic [DEFAULT_ALU_CONTROL_WIDTH-1:0] ALU_ROL = 4'b1010;
   localparam logic [DEFAULT_ALU_CONTROL_WIDTH-1:0] ALU_ROR = 4'b1011;
   localparam logic [DEFAULT_ALU_CONTROL_WIDTH-1:0] ALU_ADD = 4'b1111;

   typedef enum logic [1:0] {
      WB_IDLE  = 2'd0,
      WB_WR_LO = 2'd1,
      WB_WR_HI = 2'd2,
      WB_EXC   = 2'd3
   } wb_state_t;

endpackage

// File: rtl/alu_wb_flags.sv
// rtl/alu_wb_flags.sv - zero/negative flags of the last written low result; present only with ALU_WB_FLAGS_EN.
`ifdef ALU_WB_FLAGS_EN
module alu_wb_flags #(
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  update,
   input  logic [DATA_WIDTH-1:0] result,
   output logic                  z_flag,
   output logic                  n_flag
);

   always_ff @(posedge clk) begin
      if (rst) begin
         z_flag <= 1'b0;
         n_flag <= 1'b0;
      end else if (update) begin
         z_flag <= (result == '0);
         n_flag <= result[DATA_WIDTH-1];
      end
   end

endmodule
`endif

// File: rtl/alu_writeback.sv
// rtl/alu_writeback.sv - captures one ALU result per handshake and sequences register-file writes;
// ALU_WB_FLAGS_EN adds z_flag/n_flag outputs.
module alu_writeback
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH        = DEFAULT_DATA_WIDTH,
   parameter int ALU_CONTROL_WIDTH = DEFAULT_ALU_CONTROL_WIDTH,
   parameter int REG_ADDR_WIDTH    = 4,
   parameter int HI_REG            = 0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [ALU_CONTROL_WIDTH-1:0] alu_ctrl,
   input  logic [REG_ADDR_WIDTH-1:0]    dest_addr,
   input  logic [DATA_WIDTH-1:0]        r_in,
   input  logic [DATA_WIDTH-1:0]        s_in,
   input  logic                         alu_exc,
   input  logic                         exc_clear,
   output logic                         rf_we,
   output logic [REG_ADDR_WIDTH-1:0]    rf_waddr,
   output logic [DATA_WIDTH-1:0]        rf_wdata,
   output logic                         done,
`ifdef ALU_WB_FLAGS_EN
   output logic                         z_flag,
   output logic                         n_flag,
`endif
   output logic                         exc_flag
);

   wb_state_t                  state, state_next;
   logic [ALU_CONTROL_WIDTH-1:0] ctrl_q;
   logic [REG_ADDR_WIDTH-1:0]  dest_q;
   logic [DATA_WIDTH-1:0]      r_q;
   logic [DATA_WIDTH-1:0]      s_q;
   logic                       accept;
   logic                       two_word;

   assign accept   = in_valid && in_ready;
   assign two_word = (ctrl_q == ALU_CONTROL_WIDTH'(ALU_MUL)) ||
                     (ctrl_q == ALU_CONTROL_WIDTH'(ALU_DIV));

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= WB_IDLE;
         ctrl_q <= '0;
         dest_q <= '0;
         r_q    <= '0;
         s_q    <= '0;
      end else begin
         state <= state_next;
         if (accept) begin
            ctrl_q <= alu_ctrl;
            dest_q <= dest_addr;
            r_q    <= r_in;
            s_q    <= s_in;
         end
      end
   end

   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      rf_we      = 1'b0;
      rf_waddr   = '0;
      rf_wdata   = '0;
      done       = 1'b0;
      exc_flag   = 1'b0;
      case (state)
         WB_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_next = alu_exc ? WB_EXC : WB_WR_LO;
         end
         WB_WR_LO: begin
            rf_waddr = dest_q;
            rf_wdata = r_q;
            rf_we    = (ctrl_q != ALU_CONTROL_WIDTH'(ALU_NOP));
            if (two_word) begin
               state_next = WB_WR_HI;
            end else begin
               done       = 1'b1;
               state_next = WB_IDLE;
            end
         end
         WB_WR_HI: begin
            // HI write comes second so it wins when dest_addr == HI_REG
            rf_we      = 1'b1;
            rf_waddr   = REG_ADDR_WIDTH'(HI_REG);
            rf_wdata   = s_q;
            done       = 1'b1;
            state_next = WB_IDLE;
         end
         WB_EXC: begin
            exc_flag = 1'b1;
            if (exc_clear) state_next = WB_IDLE;
         end
         default: state_next = WB_IDLE;
      endcase
   end

`ifdef ALU_WB_FLAGS_EN
   alu_wb_flags #(.DATA_WIDTH(DATA_WIDTH)) u_flags (
      .clk    (clk),
      .rst    (rst),
      .update ((state == WB_WR_LO) && rf_we),
      .result (r_q),
      .z_flag (z_flag),
      .n_flag (n_flag)
   );
`endif

endmodule

// File: tb/tb_alu_writeback.sv
// tb/tb_alu_writeback.sv - directed bench with a write scoreboard for alu_writeback.
module tb_alu_writeback;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  alu_ctrl;
   logic [3:0]  dest_addr;
   logic [15:0] r_in;
   logic [15:0] s_in;
   logic        alu_exc;
   logic        exc_clear;
   logic        rf_we;
   logic [3:0]  rf_waddr;
   logic [15:0] rf_wdata;
   logic        done;
   logic        exc_flag;
`ifdef ALU_WB_FLAGS_EN
   logic        z_flag;
   logic        n_flag;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [3:0]  addr;
      logic [15:0] data;
   } wr_t;
   wr_t exp_q[$];

   always #5 clk = ~clk;

   alu_writeback dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .alu_ctrl  (alu_ctrl),
      .dest_addr (dest_addr),
      .r_in      (r_in),
      .s_in      (s_in),
      .alu_exc   (alu_exc),
      .exc_clear (exc_clear),
      .rf_we     (rf_we),
      .rf_waddr  (rf_waddr),
      .rf_wdata  (rf_wdata),
      .done      (done),
`ifdef ALU_WB_FLAGS_EN
      .z_flag    (z_flag),
      .n_flag    (n_flag),
`endif
      .exc_flag  (exc_flag)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_ready"}, 32'(in_ready), 32'd1);
      chk({tag, "_we"},    32'(rf_we),    32'd0);
      chk({tag, "_addr"},  32'(rf_waddr), 32'd0);
      chk({tag, "_data"},  32'(rf_wdata), 32'd0);
      chk({tag, "_done"},  32'(done),     32'd0);
      chk({tag, "_exc"},   32'(exc_flag), 32'd0);
   endtask

   task automatic chk_write(input string tag, input logic [3:0] a, input logic [15:0] d,
                            input logic dn);
      chk({tag, "_we"},    32'(rf_we),    32'd1);
      chk({tag, "_addr"},  32'(rf_waddr), 32'(a));
      chk({tag, "_data"},  32'(rf_wdata), 32'(d));
      chk({tag, "_done"},  32'(done),     32'(dn));
      chk({tag, "_ready"}, 32'(in_ready), 32'd0);
   endtask

   // scoreboard: every write the DUT issues must match the next expected one
   always @(negedge clk) begin
      if (rf_we === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL unexpected_write observed=%0h:%0h expected=none", rf_waddr, rf_wdata);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            assert ({rf_waddr, rf_wdata} === e) else begin
               errors++;
               $error("FAIL sb_write observed=%0h:%0h expected=%0h:%0h",
                      rf_waddr, rf_wdata, e.addr, e.data);
            end
         end
      end
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; alu_ctrl = '0; dest_addr = '0;
      r_in = '0; s_in = '0; alu_exc = 1'b0; exc_clear = 1'b0;
      tick(); tick();
      chk_idle("reset");
`ifdef ALU_WB_FLAGS_EN
      chk("reset_z", 32'(z_flag), 32'd0);
      chk("reset_n", 32'(n_flag), 32'd0);
`endif
      rst = 1'b0;
      tick();

      // ADD single-word
      in_valid = 1'b1; alu_ctrl = 4'b1111; dest_addr = 4'd3; r_in = 16'h0007; s_in = 16'h0000;
      exp_q.push_back('{4'd3, 16'h0007});
      tick();
      in_valid = 1'b0;
      chk_write("add_n1", 4'd3, 16'h0007, 1'b1);
      tick();
      chk_idle("add_n2");
`ifdef ALU_WB_FLAGS_EN
      chk("add_z", 32'(z_flag), 32'd0);
      chk("add_n", 32'(n_flag), 32'd0);
`endif

      // MUL two-word
      in_valid = 1'b1; alu_ctrl = 4'b0001; dest_addr = 4'd5; r_in = 16'h0000; s_in = 16'h0001;
      exp_q.push_back('{4'd5, 16'h0000});
      exp_q.push_back('{4'd0, 16'h0001});
      tick();
      in_valid = 1'b0;
      chk_write("mul_n1", 4'd5, 16'h0000, 1'b0);
      tick();
      chk_write("mul_n2", 4'd0, 16'h0001, 1'b1);
      tick();
      chk_idle("mul_n3");
`ifdef ALU_WB_FLAGS_EN
      chk("mul_z", 32'(z_flag), 32'd1);
`endif

      // exception with in_valid held high
      in_valid = 1'b1; alu_ctrl = 4'b0111; alu_exc = 1'b1; dest_addr = 4'd4; r_in = 16'hDEAD;
      tick();
      for (int i = 0; i < 10; i++) begin
         chk("exc_flag_held",  32'(exc_flag), 32'd1);
         chk("exc_ready_held", 32'(in_ready), 32'd0);
         chk("exc_done",       32'(done),     32'd0);
         tick();
      end
      in_valid = 1'b0; alu_exc = 1'b0; exc_clear = 1'b1;
      tick();
      exc_clear = 1'b0;
      chk_idle("exc_cleared");
      exc_clear = 1'b1;
      tick();
      exc_clear = 1'b0;
      chk_idle("clear_in_idle");

      // NOP retires without writing
      in_valid = 1'b1; alu_ctrl = 4'b0000; dest_addr = 4'd9; r_in = 16'h1234;
      tick();
      in_valid = 1'b0;
      chk("nop_we",    32'(rf_we),    32'd0);
      chk("nop_done",  32'(done),     32'd1);
      chk("nop_ready", 32'(in_ready), 32'd0);
      tick();
      chk_idle("nop_n2");

      // reset during WR_LO of a DIV
      in_valid = 1'b1; alu_ctrl = 4'b0010; dest_addr = 4'd6; r_in = 16'hAAAA; s_in = 16'h5555;
      exp_q.push_back('{4'd6, 16'hAAAA});
      tick();
      in_valid = 1'b0;
      chk_write("div_lo", 4'd6, 16'hAAAA, 1'b0);
      rst = 1'b1;
      tick();
      chk_idle("div_rst");
      rst = 1'b0;
      tick();
      chk_idle("div_after_rst");

      // back-to-back SUB then DIV, in_valid held
      in_valid = 1'b1; alu_ctrl = 4'b0011; dest_addr = 4'd2; r_in = 16'h0011; s_in = 16'h0000;
      exp_q.push_back('{4'd2, 16'h0011});
      exp_q.push_back('{4'd7, 16'h0022});
      exp_q.push_back('{4'd0, 16'h0033});
      tick();
      alu_ctrl = 4'b0010; dest_addr = 4'd7; r_in = 16'h0022; s_in = 16'h0033;
      chk_write("b2b_sub", 4'd2, 16'h0011, 1'b1);
      tick();
      chk("b2b_accept_ready", 32'(in_ready), 32'd1);
      chk("b2b_gap_we",       32'(rf_we),    32'd0);
      tick();
      in_valid = 1'b0;
      chk_write("b2b_div_lo", 4'd7, 16'h0022, 1'b0);
      tick();
      chk_write("b2b_div_hi", 4'd0, 16'h0033, 1'b1);
      tick();
      chk_idle("b2b_end");

      // MUL with dest == HI_REG: both writes, S last
      in_valid = 1'b1; alu_ctrl = 4'b0001; dest_addr = 4'd0; r_in = 16'h8001; s_in = 16'h00FF;
      exp_q.push_back('{4'd0, 16'h8001});
      exp_q.push_back('{4'd0, 16'h00FF});
      tick();
      in_valid = 1'b0;
      tick();
      chk_write("hi_dest_second", 4'd0, 16'h00FF, 1'b1);
`ifdef ALU_WB_FLAGS_EN
      chk("hi_dest_n", 32'(n_flag), 32'd1);
`endif
      tick();

      // a few single-word ops with random data
      for (int k = 0; k < 4; k++) begin
         logic [15:0] d;
         logic [3:0]  a;
         d = 16'($urandom);
         a = 4'($urandom_range(1, 15));
         in_valid = 1'b1; alu_ctrl = 4'b1000 + 4'(k); dest_addr = a; r_in = d; s_in = ~d;
         exp_q.push_back('{a, d});
         tick();
         in_valid = 1'b0;
         chk_write("rand_op", a, d, 1'b1);
         tick();
      end

      tick(); tick();
      chk("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_writeback.md
Name: alu_writeback

Overview:
- Downstream consumer of the ALU's combinational outputs: R (low result), S (high result / remainder) and ALU_Exception.
- Captures one ALU result per handshake and sequences register-file writes through a single write port.
- MUL/DIV produce two words, so they take two write cycles: R to the destination register, S to a fixed HI register.
- An ALU exception suppresses all writes and holds a sticky flag until the control unit clears it.

Parameters:
- DATA_WIDTH, 16, width of R, S and register data.
- ALU_CONTROL_WIDTH, 4, width of the ALU function code.
- REG_ADDR_WIDTH, 4, register-file address width.
- HI_REG, 0, register address that receives S for MUL/DIV.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream presents a valid ALU result this cycle.
- in_ready  out  1  block can accept a result this cycle.
- alu_ctrl  in  ALU_CONTROL_WIDTH  function code that produced the result.
- dest_addr  in  REG_ADDR_WIDTH  destination register for R.
- r_in  in  DATA_WIDTH  ALU R output.
- s_in  in  DATA_WIDTH  ALU S output.
- alu_exc  in  1  ALU_Exception.
- exc_clear  in  1  control unit acknowledges the exception.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  REG_ADDR_WIDTH  write address.
- rf_wdata  out  DATA_WIDTH  write data.
- done  out  1  one-cycle pulse when the operation retires.
- exc_flag  out  1  sticky exception indicator.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE, in_ready=1, rf_we=0, rf_waddr=0, rf_wdata=0, done=0, exc_flag=0. All latched operands are cleared.
- States: IDLE, WR_LO, WR_HI, EXC. in_ready=1 only in IDLE.
- Accept: the transfer occurs in the cycle where in_valid && in_ready (cycle N). On that edge the block latches alu_ctrl, dest_addr, r_in, s_in and alu_exc.
  - If alu_exc=1, go to EXC.
  - Otherwise go to WR_LO.
- WR_LO (cycle N+1):
  - rf_waddr = latched dest; rf_wdata = latched R.
  - rf_we = 1 unless latched ctrl == 0 (NOP). A NOP writes nothing.
  - If ctrl is MUL (4'b0001) or DIV (4'b0010), go to WR_HI with done=0.
  - Otherwise done=1 and return to IDLE.
- WR_HI (cycle N+2): rf_we=1, rf_waddr=HI_REG, rf_wdata=latched S, done=1, return to IDLE.
- Latency:
  - Single-word op: write in N+1, in_ready high again in N+2.
  - MUL/DIV: writes in N+1 and N+2, in_ready high again in N+3.
  - Throughput is one operation every 2 or 3 cycles.
- Outside write cycles, rf_we=0, rf_waddr=0 and rf_wdata=0.
- EXC:
  - exc_flag=1, no write, done=0, in_ready=0.
  - exc_clear=1 moves the block to IDLE and clears exc_flag on the same edge.
  - exc_clear outside EXC is ignored.
- in_valid while in_ready=0 is ignored; upstream must hold its data until accepted.
- If dest_addr == HI_REG on MUL/DIV, both writes occur and the S write (second) wins.
- Unknown function codes arrive with alu_exc=1 and are therefore handled as exceptions.
- rst in WR_LO, WR_HI or EXC aborts the operation: no further writes, no done, exc_flag cleared.
- Function codes are compared against alu_ctrl as latched at accept, never against the live input.

Optional Feature:
- Macro: ALU_WB_FLAGS_EN.
- Defined:
  - Adds outputs z_flag and n_flag, each 1 bit, reset value 0.
  - Both update only on a WR_LO cycle with rf_we=1: z_flag = (R==0), n_flag = R[DATA_WIDTH-1].
  - Both hold their value otherwise.
- Undefined: ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package alu_pkg holds the ALU function-code constants (ADD, SUB, AND, OR, MUL, DIV, SLL, SLR, ROL, ROR, NOP=0), the writeback state enum, and the DATA_WIDTH / ALU_CONTROL_WIDTH defaults. The ALU and this block both import it.
- No sub-module in the base build. The flags register under ALU_WB_FLAGS_EN is a natural sub-module, alu_wb_flags.

Test Plan:
- ADD: ctrl=4'b1111, r_in=0x0007, dest=3, accepted cycle N -> N+1: rf_we=1, addr=3, data=0x0007, done=1; N+2: in_ready=1, rf_we=0.
- MUL: ctrl=4'b0001, r_in=0x0000, s_in=0x0001, dest=5 -> N+1: write addr 5 data 0x0000, done=0; N+2: write addr 0 data 0x0001, done=1; in_ready=0 during N+1 and N+2.
- Exception: ctrl=4'b0111, alu_exc=1 -> no rf_we; exc_flag=1 and in_ready=0 held for 10 cycles with in_valid=1; exc_clear pulse -> next cycle exc_flag=0, in_ready=1.
- NOP: ctrl=0 -> N+1: rf_we=0, done=1, no register changes.
- Reset mid-DIV: rst asserted in the WR_LO cycle -> no HI_REG write at N+2; all outputs at reset values; in_ready=1.
- Back-to-back SUB then DIV with in_valid held high -> DIV accepted in N+2 only, not N+1; write order is SUB dest, DIV dest, HI_REG.
